// File: rtl/dp_pkg.sv
// Shared datapath definitions: operand/address types, ALU opcodes and the
// decode helper that decides which instructions update the carry/overflow flag.
package dp_pkg;

    localparam int DATA_W    = 8;
    localparam int REG_AW    = 4;
    localparam int REG_DEPTH = 1 << REG_AW;
    localparam int CNT_W     = 8;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [CNT_W-1:0]  wr_count_t;
    typedef logic [3:0]        alu_op_t;

    localparam alu_op_t OP_ADD  = 4'b0000;
    localparam alu_op_t OP_SUB  = 4'b0001;
    localparam alu_op_t OP_NAND = 4'b0110;
    localparam alu_op_t OP_OR   = 4'b0111;
    localparam alu_op_t OP_SLL  = 4'b1000;
    localparam alu_op_t OP_SRL  = 4'b1001;
    localparam alu_op_t OP_LT   = 4'b1101;
    localparam alu_op_t OP_EQL  = 4'b1110;

    // Only the arithmetic ops produce a carry that a following op may chain on.
    function automatic logic op_writes_flag(input alu_op_t op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/reg_file_flags_if.sv
// Register-file bus between decode/ALU (master) and the register file (slave).
// No handshake: reads are combinational every cycle, writes commit at the rising edge when enabled.
interface reg_file_flags_if;
    import dp_pkg::*;

    reg_addr_t RaddrA;
    reg_addr_t RaddrB;
    reg_addr_t Waddr;
    logic      WriteEn;
    data_t     DataIn;
    logic      FlagWriteEn;
    logic      FlagIn;
    logic      FlagClear;
    data_t     DataOutA;
    data_t     DataOutB;
    logic      FlagOut;
    wr_count_t WrCount;

    modport master (
        output RaddrA, RaddrB, Waddr, WriteEn, DataIn,
        output FlagWriteEn, FlagIn, FlagClear,
        input  DataOutA, DataOutB, FlagOut, WrCount
    );

    modport slave (
        input  RaddrA, RaddrB, Waddr, WriteEn, DataIn,
        input  FlagWriteEn, FlagIn, FlagClear,
        output DataOutA, DataOutB, FlagOut, WrCount
    );

endinterface

// File: rtl/flag_reg.sv
// Single carry/overflow flag bit with clear > write > hold priority,
// kept separate so that priority can be exercised on its own.
module flag_reg (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic we_i,
    input  logic d_i,
    output logic q_o
);

    logic flag_q;
    logic flag_d;

    // Clear wins so a chain can be started even on a cycle that also writes the flag.
    always_comb begin
        flag_d = flag_q;
        if (clear_i) begin
            flag_d = 1'b0;
        end else if (we_i) begin
            flag_d = d_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            flag_q <= 1'b0;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign q_o = flag_q;

endmodule

// File: rtl/reg_file_flags.sv
// 16 x 8-bit architectural register file with two combinational read ports,
// one write port, the ALU carry flag and a saturating write counter.
module reg_file_flags
    import dp_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    reg_file_flags_if.slave  bus
);

    data_t     regs_q [REG_DEPTH];
    data_t     regs_d [REG_DEPTH];
    wr_count_t wr_count_q;
    wr_count_t wr_count_d;

    always_comb begin
        regs_d = regs_q;
        if (bus.WriteEn) begin
            regs_d[bus.Waddr] = bus.DataIn;
        end
    end

    always_comb begin
        wr_count_d = wr_count_q;
        if (bus.WriteEn && (wr_count_q != '1)) begin
            wr_count_d = wr_count_q + 8'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < REG_DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            wr_count_q <= '0;
        end else begin
            regs_q     <= regs_d;
            wr_count_q <= wr_count_d;
        end
    end

    // Reads come straight from stored state; DataIn is built from these outputs
    // through the ALU, so a write bypass here would close a combinational loop.
    assign bus.DataOutA = regs_q[bus.RaddrA];
    assign bus.DataOutB = regs_q[bus.RaddrB];
    assign bus.WrCount  = wr_count_q;

    flag_reg u_flag_reg (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .clear_i (bus.FlagClear),
        .we_i    (bus.FlagWriteEn),
        .d_i     (bus.FlagIn),
        .q_o     (bus.FlagOut)
    );

endmodule
